// File: rtl/axis_pkg.sv
// ============================================================================
// Package     : axis_pkg
// Description : Shared AXI4-Stream helpers. Provides the per-slice keep
//               reduction used by the width downsizer and the constants and
//               function that decide whether an IN/OUT width pair is legal.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axis_pkg;

    // Widest tkeep the helpers accept (1024-bit tdata).
    localparam int MAX_KEEP_BITS = 128;
    // Mask width returned by slice_nonzero. It is kept strictly larger than
    // any legal ratio so callers can always slice off an unused upper part.
    localparam int MAX_RATIO     = 2 * MAX_KEEP_BITS;
    localparam int MIN_RATIO     = 2;

    // True when in_w/out_w is an integer power-of-two ratio of at least
    // MIN_RATIO, both widths are whole bytes and the keep fits the helpers.
    function automatic bit ratio_is_legal(input int in_w, input int out_w);
        int r;
        if (out_w <= 0 || in_w <= 0)           return 1'b0;
        if ((in_w % 8) != 0 || (out_w % 8) != 0) return 1'b0;
        if ((in_w % out_w) != 0)                return 1'b0;
        if ((in_w / 8) > MAX_KEEP_BITS)         return 1'b0;
        r = in_w / out_w;
        if (r < MIN_RATIO || r >= MAX_RATIO)    return 1'b0;
        return ((r & (r - 1)) == 0);
    endfunction

    // Bit k of the result is set when keep bytes
    // [k*slice_bytes +: slice_bytes] contain at least one set bit.
    function automatic logic [MAX_RATIO-1:0] slice_nonzero(
        input logic [MAX_KEEP_BITS-1:0] keep,
        input int                       slice_bytes
    );
        logic [MAX_RATIO-1:0] m;
        m = '0;
        if (slice_bytes > 0) begin
            for (int b = 0; b < MAX_KEEP_BITS; b++) begin
                m[b / slice_bytes] = m[b / slice_bytes] | keep[b];
            end
        end
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lane_prio_find.sv
// ============================================================================
// Module      : lane_prio_find
// Description : Priority finder. Returns the lowest set bit of mask_i whose
//               index is greater than or equal to start_i.
// Ports       : mask_i  - N-bit candidate mask
//               start_i - first index eligible (may equal N: nothing found)
//               idx_o   - lowest eligible set index (0 when none)
//               found_o - an eligible set bit exists
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lane_prio_find #(
    parameter int N = 8
) (
    input  logic [N-1:0]           mask_i,
    input  logic [$clog2(N):0]     start_i,
    output logic [$clog2(N)-1:0]   idx_o,
    output logic                   found_o
);

    localparam int IW = $clog2(N);

    // Scan from the top down so the last match written is the lowest one.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask_i[i] && (i >= int'(start_i))) begin
                idx_o   = IW'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/axis_width_downsizer.sv
// ============================================================================
// Module      : axis_width_downsizer
// Description : Serialises wide AXI4-Stream beats into OUT_WIDTH beats,
//               lowest lane first, skipping slices whose tkeep is all zero.
//               A keep-less beat carrying tlast becomes one empty tlast beat
//               so packet boundaries survive.
// Ports       : clk, rst_n            - clock, async active-low reset
//               i_data_t*             - wide slave stream
//               o_data_t*             - narrow master stream
//               busy                  - holding register occupied
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_width_downsizer
    import axis_pkg::*;
#(
    parameter int IN_WIDTH  = 512,
    parameter int OUT_WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic [IN_WIDTH-1:0]    i_data_tdata,
    input  logic [IN_WIDTH/8-1:0]  i_data_tkeep,
    input  logic                   i_data_tlast,
    input  logic                   i_data_tvalid,
    output logic                   i_data_tready,

    output logic [OUT_WIDTH-1:0]   o_data_tdata,
    output logic [OUT_WIDTH/8-1:0] o_data_tkeep,
    output logic                   o_data_tlast,
    output logic                   o_data_tvalid,
    input  logic                   o_data_tready,

    output logic                   busy
);

    localparam int RATIO    = IN_WIDTH / OUT_WIDTH;
    localparam int IW       = $clog2(RATIO);
    localparam int KEEP_IN  = IN_WIDTH / 8;
    localparam int KEEP_OUT = OUT_WIDTH / 8;

    if (!ratio_is_legal(IN_WIDTH, OUT_WIDTH)) begin : g_bad_ratio
        $error("axis_width_downsizer: IN_WIDTH/OUT_WIDTH must be a power-of-two ratio >= 2");
    end

    // ------------------------------------------------------------------
    // Holding register
    // ------------------------------------------------------------------
    logic [IN_WIDTH-1:0] hold_data_q,  hold_data_d;
    logic [KEEP_IN-1:0]  hold_keep_q,  hold_keep_d;
    logic                hold_last_q,  hold_last_d;
    logic                hold_valid_q, hold_valid_d;
    logic [IW-1:0]       idx_q,        idx_d;

    // ------------------------------------------------------------------
    // Slice occupancy masks for the incoming and the held beat
    // ------------------------------------------------------------------
    logic [MAX_RATIO-1:0] w_in_mask_full;
    logic [MAX_RATIO-1:0] w_hold_mask_full;
    logic [RATIO-1:0]     w_in_mask;
    logic [RATIO-1:0]     w_hold_mask;
    logic                 w_unused_mask_bits;

    assign w_in_mask_full   = slice_nonzero(MAX_KEEP_BITS'(i_data_tkeep), KEEP_OUT);
    assign w_hold_mask_full = slice_nonzero(MAX_KEEP_BITS'(hold_keep_q), KEEP_OUT);
    assign w_in_mask        = w_in_mask_full[RATIO-1:0];
    assign w_hold_mask      = w_hold_mask_full[RATIO-1:0];
    assign w_unused_mask_bits = ^{w_in_mask_full[MAX_RATIO-1:RATIO],
                                  w_hold_mask_full[MAX_RATIO-1:RATIO]};

    logic [IW-1:0] w_load_idx;
    logic          w_load_found;
    logic [IW-1:0] w_next_idx;
    logic          w_next_found;
    logic [IW:0]   w_next_start;

    assign w_next_start = {1'b0, idx_q} + 1'b1;

    // First slice to emit for a freshly accepted beat.
    lane_prio_find #(.N(RATIO)) u_find_load (
        .mask_i  (w_in_mask),
        .start_i ('0),
        .idx_o   (w_load_idx),
        .found_o (w_load_found)
    );

    // Next occupied slice above the one currently on the output.
    lane_prio_find #(.N(RATIO)) u_find_next (
        .mask_i  (w_hold_mask),
        .start_i (w_next_start),
        .idx_o   (w_next_idx),
        .found_o (w_next_found)
    );

    // Nothing occupied above idx: this covers both "idx is the highest
    // occupied slice" and the keep-less tlast beat parked at idx 0.
    logic w_final;
    logic w_in_hs;
    logic w_out_hs;

    assign w_final  = !w_next_found;
    assign w_in_hs  = i_data_tvalid && i_data_tready;
    assign w_out_hs = hold_valid_q && o_data_tready;

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign i_data_tready = !hold_valid_q || (w_final && o_data_tready);
    assign o_data_tvalid = hold_valid_q;
    assign o_data_tdata  = hold_data_q[idx_q*OUT_WIDTH +: OUT_WIDTH];
    assign o_data_tkeep  = hold_keep_q[idx_q*KEEP_OUT +: KEEP_OUT];
    assign o_data_tlast  = hold_last_q && w_final;
    assign busy          = hold_valid_q;

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        hold_data_d  = hold_data_q;
        hold_keep_d  = hold_keep_q;
        hold_last_d  = hold_last_q;
        hold_valid_d = hold_valid_q;
        idx_d        = idx_q;

        if (w_in_hs) begin
            // An input handshake only happens when the register is empty or
            // its final slice is leaving this cycle, so it may overwrite.
            if (w_load_found || i_data_tlast) begin
                hold_data_d  = i_data_tdata;
                hold_keep_d  = i_data_tkeep;
                hold_last_d  = i_data_tlast;
                hold_valid_d = 1'b1;
                idx_d        = w_load_idx;   // 0 for a keep-less tlast beat
            end else begin
                // Keep-less, non-last beat: swallow it.
                hold_valid_d = 1'b0;
            end
        end else if (w_out_hs) begin
            if (w_final) begin
                hold_valid_d = 1'b0;
            end else begin
                idx_d = w_next_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data_q  <= '0;
            hold_keep_q  <= '0;
            hold_last_q  <= 1'b0;
            hold_valid_q <= 1'b0;
            idx_q        <= '0;
        end else begin
            hold_data_q  <= hold_data_d;
            hold_keep_q  <= hold_keep_d;
            hold_last_q  <= hold_last_d;
            hold_valid_q <= hold_valid_d;
            idx_q        <= idx_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axis_width_downsizer.sv
// ============================================================================
// Module      : tb_axis_width_downsizer
// Description : Self-checking bench for axis_width_downsizer (512 -> 64).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_width_downsizer;

    localparam int IN_W  = 512;
    localparam int OUT_W = 64;
    localparam int NS    = IN_W / OUT_W;

    logic              clk;
    logic              rst_n;
    logic [IN_W-1:0]   i_tdata;
    logic [IN_W/8-1:0] i_tkeep;
    logic              i_tlast;
    logic              i_tvalid;
    logic              i_tready;
    logic [OUT_W-1:0]  o_tdata;
    logic [OUT_W/8-1:0] o_tkeep;
    logic              o_tlast;
    logic              o_tvalid;
    logic              o_tready;
    logic              busy;

    axis_width_downsizer #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_data_tdata  (i_tdata),
        .i_data_tkeep  (i_tkeep),
        .i_data_tlast  (i_tlast),
        .i_data_tvalid (i_tvalid),
        .i_data_tready (i_tready),
        .o_data_tdata  (o_tdata),
        .o_data_tkeep  (o_tkeep),
        .o_data_tlast  (o_tlast),
        .o_data_tvalid (o_tvalid),
        .o_data_tready (o_tready),
        .busy          (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------
    // Check bookkeeping
    // ------------------------------------------------------------------
    int passed = 0;
    int failed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: expected narrow beats in order
    // ------------------------------------------------------------------
    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        fin;    // last narrow beat of its wide beat
    } item_t;

    item_t sb[$];
    int    hs_cyc[$];
    int    cyc = 0;

    function automatic void model_push(input logic [IN_W-1:0] d,
                                       input logic [IN_W/8-1:0] k,
                                       input logic l);
        int    hi;
        item_t it;
        hi = -1;
        for (int s = 0; s < NS; s++)
            if (k[s*8 +: 8] != 8'h00) hi = s;
        if (hi < 0) begin
            if (l) begin
                it.data = d[63:0];
                it.keep = 8'h00;
                it.last = 1'b1;
                it.fin  = 1'b1;
                sb.push_back(it);
            end
            return;
        end
        for (int s = 0; s < NS; s++) begin
            if (k[s*8 +: 8] != 8'h00) begin
                it.data = d[s*64 +: 64];
                it.keep = k[s*8 +: 8];
                it.last = l && (s == hi);
                it.fin  = (s == hi);
                sb.push_back(it);
            end
        end
    endfunction

    // ------------------------------------------------------------------
    // Output-ready driver: 0 = fixed, 1 = random, 2 = alternate
    // ------------------------------------------------------------------
    int   ot_mode  = 0;
    logic ot_fixed = 1'b1;

    initial begin
        o_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ot_mode)
                1:       o_tready = 1'($urandom_range(0, 1));
                2:       o_tready = !o_tready;
                default: o_tready = ot_fixed;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output monitor, sampled on the falling edge
    // ------------------------------------------------------------------
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data;
    logic [7:0]  prev_keep;
    logic        prev_last;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", 64'(o_tvalid), 64'd1);
                    chk("stall_data",  o_tdata, prev_data);
                    chk("stall_keep",  64'(o_tkeep), 64'(prev_keep));
                    chk("stall_last",  64'(o_tlast), 64'(prev_last));
                end
                chk("busy_eq_valid", 64'(busy), 64'(o_tvalid));
                if (o_tvalid) begin
                    if (sb.size() == 0) begin
                        chk("spurious_valid", 64'(o_tvalid), 64'd0);
                    end else begin
                        chk("in_ready", 64'(i_tready), 64'(sb[0].fin && o_tready));
                        if (o_tready) begin
                            chk("out_data", o_tdata, sb[0].data);
                            chk("out_keep", 64'(o_tkeep), 64'(sb[0].keep));
                            chk("out_last", 64'(o_tlast), 64'(sb[0].last));
                            void'(sb.pop_front());
                            hs_cyc.push_back(cyc);
                        end
                    end
                end else begin
                    chk("in_ready_idle", 64'(i_tready), 64'd1);
                end
                prev_stall = o_tvalid && !o_tready;
                prev_data  = o_tdata;
                prev_keep  = o_tkeep;
                prev_last  = o_tlast;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (always entered and left at posedge + 1)
    // ------------------------------------------------------------------
    task automatic send(input logic [IN_W-1:0] d, input logic [IN_W/8-1:0] k, input logic l);
        bit accepted;
        accepted = 1'b0;
        i_tdata  = d;
        i_tkeep  = k;
        i_tlast  = l;
        i_tvalid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (i_tready) begin
                model_push(d, k, l);
                accepted = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!accepted) chk("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        i_tvalid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 500; i++) begin
            if (sb.size() == 0 && !busy) break;
            @(posedge clk);
            #1;
        end
        chk("drain_done", 64'(sb.size() == 0 && !busy), 64'd1);
    endtask

    function automatic logic [IN_W-1:0] rand_data();
        logic [IN_W-1:0] d;
        for (int w = 0; w < IN_W / 32; w++) d[w*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [IN_W/8-1:0] rand_keep();
        logic [IN_W/8-1:0] k;
        case ($urandom_range(0, 3))
            0: k = '1;
            1: k = '0;
            2: begin
                k = '0;
                for (int s = 0; s < NS; s++)
                    if ($urandom_range(0, 1) == 1) k[s*8 +: 8] = 8'hFF;
            end
            default: k = {$urandom, $urandom};
        endcase
        return k;
    endfunction

    // ------------------------------------------------------------------
    // Directed then randomized sequence
    // ------------------------------------------------------------------
    logic [IN_W-1:0] d;

    initial begin
        rst_n    = 1'b0;
        i_tvalid = 1'b0;
        i_tdata  = '0;
        i_tkeep  = '0;
        i_tlast  = 1'b0;

        // Reset state
        #1;
        chk("rst_tvalid", 64'(o_tvalid), 64'd0);
        chk("rst_busy",   64'(busy),     64'd0);
        chk("rst_tready", 64'(i_tready), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full beat, slice k carries k
        for (int s = 0; s < NS; s++) d[s*64 +: 64] = 64'(s);
        hs_cyc.delete();
        send(d, '1, 1'b1);
        drain();
        chk("full_count", 64'(hs_cyc.size()), 64'd8);
        chk("full_span",  64'(hs_cyc[hs_cyc.size()-1] - hs_cyc[0]), 64'd7);

        // Sparse keep: slices 0 and 2
        hs_cyc.delete();
        send(rand_data(), 64'h0000_0000_00FF_00FF, 1'b1);
        drain();
        chk("sparse_count", 64'(hs_cyc.size()), 64'd2);
        chk("sparse_span",  64'(hs_cyc[hs_cyc.size()-1] - hs_cyc[0]), 64'd1);

        // Single partial slice
        hs_cyc.delete();
        send(rand_data(), 64'h0000_0000_0000_0F00, 1'b1);
        drain();
        chk("single_count", 64'(hs_cyc.size()), 64'd1);

        // Three back-to-back full beats, tlast only on the third
        hs_cyc.delete();
        send(rand_data(), '1, 1'b0);
        send(rand_data(), '1, 1'b0);
        send(rand_data(), '1, 1'b1);
        drain();
        chk("b2b_count", 64'(hs_cyc.size()), 64'd24);
        chk("b2b_span",  64'(hs_cyc[hs_cyc.size()-1] - hs_cyc[0]), 64'd23);

        // Alternating output ready during a full beat
        ot_mode = 2;
        hs_cyc.delete();
        send(rand_data(), '1, 1'b1);
        drain();
        ot_mode = 0;
        chk("stall_count", 64'(hs_cyc.size()), 64'd8);

        // Keep-less beats
        hs_cyc.delete();
        send(rand_data(), '0, 1'b0);
        drain();
        chk("zero_nolast_count", 64'(hs_cyc.size()), 64'd0);
        hs_cyc.delete();
        send(rand_data(), '0, 1'b1);
        drain();
        chk("zero_last_count", 64'(hs_cyc.size()), 64'd1);

        // Reset in the middle of a beat
        hs_cyc.delete();
        send(rand_data(), '1, 1'b1);
        for (int i = 0; i < 50 && hs_cyc.size() < 3; i++) @(negedge clk);
        chk("pre_reset_hs", 64'(hs_cyc.size()), 64'd3);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_tvalid", 64'(o_tvalid), 64'd0);
        chk("midrst_busy",   64'(busy),     64'd0);
        sb.delete();
        hs_cyc.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("postrst_tready", 64'(i_tready), 64'd1);
        chk("postrst_tvalid", 64'(o_tvalid), 64'd0);
        send(rand_data(), 64'h0000_FF00_3C00_0000, 1'b1);
        drain();
        chk("postrst_count", 64'(hs_cyc.size()), 64'd2);

        // Randomized traffic with random output back-pressure
        ot_mode = 1;
        for (int n = 0; n < 150; n++) begin
            send(rand_data(), rand_keep(), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 1)) begin
                @(posedge clk);
                #1;
            end
        end
        drain();
        ot_mode = 0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
